// File: rtl/dm_lsu.sv
// -----------------------------------------------------------------------------
// dm_lsu : multicycle load/store sequencer for a byte-wide synchronous RAM.
//
// Takes one B/H/W/Bu/Hu request from the core, walks it out over the byte
// RAM one byte per cycle (little-endian, base + k with wrap-around), and for
// loads reassembles and sign/zero-extends the result into DataRd. Completion
// is a one-cycle Ready pulse; Err qualifies Ready for rejected requests.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   Req             : request valid, sampled only in IDLE
//   DMWr            : 1 = store, 0 = load
//   DMCtrl[2:0]     : 000 B, 001 H, 010 W, 100 Bu, 101 Hu (others illegal)
//   Address[31:0]   : byte address, low ADDR_W bits used
//   DataWr[31:0]    : store data, low 8/16/32 bits used
//   DataRd[31:0]    : registered load result, held until the next good load
//   Ready, Err      : completion pulse / rejected-request qualifier
//   Busy            : high in every state except IDLE
//   MemAddr         : RAM byte address
//   MemWrData[7:0]  : RAM write byte
//   MemWe, MemRe    : RAM write / read enable (never both, only in ISSUE)
//   MemRdData[7:0]  : RAM read byte, valid the cycle after MemRe
//
// Configuration
//   DM_LSU_ALIGN_CHECK_EN : when defined, misaligned H/Hu/W requests are
//                           rejected; otherwise any alignment is sequenced
//                           with wrap-around.
// -----------------------------------------------------------------------------
module dm_lsu #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Req,
  input  logic              DMWr,
  input  logic [2:0]        DMCtrl,
  input  logic [31:0]       Address,
  input  logic [31:0]       DataWr,
  output logic [31:0]       DataRd,
  output logic              Ready,
  output logic              Err,
  output logic              Busy,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [7:0]        MemWrData,
  output logic              MemWe,
  output logic              MemRe,
  input  logic [7:0]        MemRdData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [1:0]        k_q, k_d;
  logic [2:0][7:0]   lane_q, lane_d;    // bytes 0..N-2 of a load
  logic [31:0]       data_rd_q, data_rd_d;

  logic              illegal;
  logic [1:0]        last_k;
  logic [31:0]       word;

  // Only the RAM-sized part of the core address reaches the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Address[31:ADDR_W];

  // Request legality, evaluated on the live request inputs in IDLE.
  always_comb begin
    illegal = (DMCtrl == 3'b011) || (DMCtrl[2:1] == 2'b11) || (DMCtrl[2] && DMWr);
`ifdef DM_LSU_ALIGN_CHECK_EN
    if (DMCtrl[1:0] == 2'b01 && Address[0])          illegal = 1'b1;
    if (DMCtrl[1:0] == 2'b10 && Address[1:0] != 2'b00) illegal = 1'b1;
`endif
  end

  // Index of the final byte: 0 for B/Bu, 1 for H/Hu, 3 for W.
  always_comb begin
    case (ctrl_q[1:0])
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  // Assembled load word; the last byte comes straight off the RAM in CAPT.
  // Unused upper bytes are zero, so Bu/Hu/W need no further extension.
  always_comb begin
    case (ctrl_q[1:0])
      2'b00:   word = {24'h0, MemRdData};
      2'b01:   word = {16'h0, MemRdData, lane_q[0]};
      default: word = {MemRdData, lane_q[2], lane_q[1], lane_q[0]};
    endcase
  end

  always_comb begin
    // NOTE: every next-state and output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    ctrl_d    = ctrl_q;
    wr_d      = wr_q;
    err_d     = err_q;
    k_d       = k_q;
    lane_d    = lane_q;
    data_rd_d = data_rd_q;
    Ready     = 1'b0;
    Err       = 1'b0;
    Busy      = (state_q != S_IDLE);
    MemAddr   = '0;
    MemWrData = '0;
    MemWe     = 1'b0;
    MemRe     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Req) begin
          base_d  = Address[ADDR_W-1:0];
          wdata_d = DataWr;
          ctrl_d  = DMCtrl;
          wr_d    = DMWr;
          err_d   = illegal;
          k_d     = 2'd0;
          state_d = illegal ? S_DONE : S_ISSUE;
        end
      end

      S_ISSUE: begin
        // Natural ADDR_W-bit overflow gives the wrap from the top byte to 0.
        MemAddr = base_q + ADDR_W'(k_q);
        if (wr_q) begin
          MemWe     = 1'b1;
          MemWrData = wdata_q[{k_q, 3'b000} +: 8];
        end else begin
          MemRe = 1'b1;
          // Read data lags the enable by a cycle: this is byte k-1.
          if (k_q != 2'd0) lane_d[k_q - 2'd1] = MemRdData;
        end
        if (k_q == last_k) begin
          state_d = wr_q ? S_DONE : S_CAPT;
        end else begin
          k_d = k_q + 2'd1;
        end
      end

      S_CAPT: begin
        case (ctrl_q)
          3'b000:  data_rd_d = {{24{word[7]}}, word[7:0]};
          3'b001:  data_rd_d = {{16{word[15]}}, word[15:0]};
          default: data_rd_d = word;
        endcase
        state_d = S_DONE;
      end

      S_DONE: begin
        Ready   = 1'b1;
        Err     = err_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      wdata_q   <= '0;
      ctrl_q    <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      k_q       <= '0;
      // NOTE: the lane bytes are plain flops, not a RAM, so they are reset
      // like the rest; a RAM array would be left unreset.
      lane_q    <= '0;
      data_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      ctrl_q    <= ctrl_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      k_q       <= k_d;
      lane_q    <= lane_d;
      data_rd_q <= data_rd_d;
    end
  end

  assign DataRd = data_rd_q;

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Multicycle load/store sequencer that sits between the core's data-memory request port and a byte-wide, synchronous-read data RAM. It accepts one B/H/W/Bu/Hu request and issues one byte access per cycle, little-endian. For loads it reassembles and sign- or zero-extends the result. It is the initiator for the byte RAM and signals completion to the core with a one-cycle `Ready` pulse.

## Interface
- `ADDR_W`, default 10: RAM byte-address width (1024 bytes).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `Req` in 1: request valid; sampled only in IDLE.
- `DMWr` in 1: 1 = store, 0 = load.
- `DMCtrl` in 3: access type. 000 = B, 001 = H, 010 = W, 100 = Bu, 101 = Hu.
- `Address` in 32: byte address; only bits `[ADDR_W-1:0]` are used.
- `DataWr` in 32: store data; low 8/16/32 bits are used.
- `DataRd` out 32: registered load result.
- `Ready` out 1: one-cycle completion pulse.
- `Err` out 1: qualifies `Ready` to mean the request was rejected.
- `Busy` out 1: high in every state except IDLE.
- `MemAddr` out ADDR_W: RAM byte address.
- `MemWrData` out 8: RAM write byte.
- `MemWe` out 1: RAM write enable.
- `MemRe` out 1: RAM read enable.
- `MemRdData` in 8: RAM read byte, valid the cycle after `MemRe`.

## Operation
- States: IDLE, ISSUE, CAPT, DONE.
- **IDLE**
  - If `Req` = 1, latch `Address`, `DataWr`, `DMCtrl` and `DMWr`.
  - Byte count N: 1 for B/Bu, 2 for H/Hu, 4 for W.
  - Clear byte index k.
  - Next state: ISSUE if the request is legal, otherwise DONE with `Err` = 1.
- **Illegal requests**
  - `DMCtrl` in {011, 110, 111}.
  - Bu or Hu with `DMWr` = 1.
  - Under DM_LSU_ALIGN_CHECK_EN, also a misaligned request.
- **ISSUE** (one byte per cycle)
  - `MemAddr` = base + k, modulo 2^ADDR_W, so accesses wrap 0x3FF to 0x000.
  - Store: `MemWe` = 1 and `MemWrData` = `DataWr[8k+7:8k]`.
  - Load: `MemRe` = 1. From k ≥ 1, the `MemRdData` byte from the previous issue is captured into lane k-1.
  - Leave ISSUE after k = N-1: stores go to DONE, loads go to CAPT.
- **CAPT** (loads only)
  - Capture the last byte into lane N-1. No RAM enable is asserted.
  - Extend and register the result: B/H sign-extend from bit 7/15, Bu/Hu zero-extend, W passes through.
  - `DataRd` updates on the edge into DONE.
- **DONE**
  - `Ready` = 1 for exactly one cycle. `Err` = 1 only for a rejected request.
  - Next state: IDLE.
- `DataRd` holds its value until the next successful load completes. Stores and errors leave it unchanged.
- `Req` is ignored in ISSUE, CAPT and DONE, so no back-to-back acceptance happens from the DONE state.
- `MemWe` and `MemRe` are never high in the same cycle. Both are low outside ISSUE.

## Timing
- Cycle 0 is the IDLE cycle in which `Req` is sampled high.
- Store: ISSUE occupies cycles 1..N and `Ready` is high in cycle N+1. W store: `Ready` in cycle 5.
- Load: ISSUE occupies cycles 1..N, CAPT is cycle N+1, and `Ready` plus the new `DataRd` appear in cycle N+2. W load: `Ready` in cycle 6.
- Error: `Ready` and `Err` are high in cycle 1, with no RAM traffic.
- Earliest next acceptance is the cycle after `Ready`.
- Reset (asynchronous, any state):
  - Go to IDLE immediately.
  - `DataRd`, `Ready`, `Err`, `Busy`, `MemAddr`, `MemWrData`, `MemWe` and `MemRe` all go to 0.
  - A store interrupted mid-sequence leaves its already-written bytes in RAM. No rollback is done.

## Configuration
- Macro: DM_LSU_ALIGN_CHECK_EN.
- Defined:
  - H/Hu with `Address[0]` ≠ 0 is rejected.
  - W with `Address[1:0]` ≠ 0 is rejected.
  - A rejected request produces `Ready` and `Err` in cycle 1 with no RAM traffic.
- Undefined: any alignment is legal. Bytes are sequenced from the base address with wrap-around.

## Test plan
- Store W `DataWr` = 0x11223344 at `Address` = 0x10:
  - Cycles 1-4: `MemWe` with bytes 44, 33, 22, 11 at addresses 0x10-0x13.
  - Cycle 5: `Ready` = 1, `Err` = 0.
- Store B 0x80 at 0x20, then load B at 0x20 and load Bu at 0x20:
  - Load B: `DataRd` = 0xFFFFFF80.
  - Load Bu: `DataRd` = 0x00000080.
  - Each load's `Ready` is in its cycle 3.
- Store H 0x8001 at 0x30, then load H and load Hu at 0x30:
  - Load H: `DataRd` = 0xFFFF8001.
  - Load Hu: `DataRd` = 0x00008001.
- `DMCtrl` = 011, and separately Bu with `DMWr` = 1:
  - Cycle 1: `Ready` = 1 and `Err` = 1.
  - `MemWe` and `MemRe` stay 0.
  - Prior `DataRd` is unchanged.
- Alignment:
  - Without the macro, store H 0xBEEF at 0x3FF: 0xEF is written to 0x3FF and 0xBE to 0x000. Load H at 0x3FF returns 0xFFFFBEEF.
  - With the macro, load H at 0x11 gets `Err` in cycle 1 and no RAM access.
- Reset mid-operation: assert `rst` in cycle 3 of a W store of 0xAABBCCDD at 0x40.
  - All outputs go to 0 and the block is in IDLE.
  - Bytes 0x40-0x41 hold DD and CC; bytes 0x42-0x43 are unchanged.
  - A new `Req` after reset is accepted normally.
